// File: rtl/xif_id_tracker.sv
// In-order tracker for offloaded FPU instructions.
// Holds issued IDs until commit and completion, then returns results.
module xif_id_tracker #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic                       issue_accept,
    input  logic                       issue_writeback,
    input  logic [X_ID_WIDTH-1:0]      issue_id,
    input  logic [4:0]                 issue_rd,
    input  logic                       commit_valid,
    input  logic [X_ID_WIDTH-1:0]      commit_id,
    input  logic                       commit_kill,
    input  logic                       exec_valid,
    input  logic [X_ID_WIDTH-1:0]      exec_id,
    input  logic [X_RFW_WIDTH-1:0]     exec_data,
    input  logic                       exec_exc,
    input  logic [5:0]                 exec_exccode,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [X_ID_WIDTH-1:0]      result_id,
    output logic [X_RFW_WIDTH-1:0]     result_data,
    output logic [4:0]                 result_rd,
    output logic                       result_we,
    output logic                       result_exc,
    output logic [5:0]                 result_exccode,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_ISSUED,
        ST_COMMITTED,
        ST_KILLED
    } state_e;

    state_e                 state_q   [DEPTH];
    state_e                 state_d   [DEPTH];
    logic                   done_q    [DEPTH];
    logic                   done_d    [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q      [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_d      [DEPTH];
    logic [4:0]             rd_q      [DEPTH];
    logic [4:0]             rd_d      [DEPTH];
    logic                   wb_q      [DEPTH];
    logic                   wb_d      [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q    [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_d    [DEPTH];
    logic                   exc_q     [DEPTH];
    logic                   exc_d     [DEPTH];
    logic [5:0]             code_q    [DEPTH];
    logic [5:0]             code_d    [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          cmt_hit, exe_hit;
    logic [PW-1:0] cmt_idx, exe_idx, idx;
    logic          alloc, pop, kill_free, free;

    assign issue_ready = (count_q != CW'(DEPTH));
    assign alloc       = issue_valid & issue_ready & issue_accept;
    assign count       = count_q;

    assign result_valid = (state_q[head_q] == ST_COMMITTED) & done_q[head_q];
    assign kill_free    = (state_q[head_q] == ST_KILLED);
    assign pop          = result_valid & result_ready;
    assign free         = pop | kill_free;

    assign result_id      = result_valid ? id_q[head_q]   : '0;
    assign result_data    = result_valid ? data_q[head_q] : '0;
    assign result_rd      = result_valid ? rd_q[head_q]   : '0;
    assign result_exc     = result_valid ? exc_q[head_q]  : 1'b0;
    assign result_exccode = result_valid ? code_q[head_q] : '0;
    assign result_we      = result_valid & wb_q[head_q] & ~exc_q[head_q];

    // Oldest-first search for the commit and exec targets
    always_comb begin
        cmt_hit = 1'b0;
        cmt_idx = '0;
        exe_hit = 1'b0;
        exe_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (!cmt_hit && state_q[idx] == ST_ISSUED &&
                id_q[idx] == commit_id) begin
                cmt_hit = 1'b1;
                cmt_idx = idx;
            end
            if (!exe_hit && state_q[idx] != ST_FREE && !done_q[idx] &&
                id_q[idx] == exec_id) begin
                exe_hit = 1'b1;
                exe_idx = idx;
            end
        end
    end

    // Next-state: commit/exec updates, then head free, then tail alloc
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        id_d    = id_q;
        rd_d    = rd_q;
        wb_d    = wb_q;
        data_d  = data_q;
        exc_d   = exc_q;
        code_d  = code_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(alloc) - CW'(free);
        if (commit_valid && cmt_hit) begin
            state_d[cmt_idx] = commit_kill ? ST_KILLED : ST_COMMITTED;
        end
        if (exec_valid && exe_hit) begin
            done_d[exe_idx] = 1'b1;
            data_d[exe_idx] = exec_data;
            exc_d[exe_idx]  = exec_exc;
            code_d[exe_idx] = exec_exccode;
        end
        if (free) begin
            state_d[head_q] = ST_FREE;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (alloc) begin
            state_d[tail_q] = ST_ISSUED;
            done_d[tail_q]  = 1'b0;
            id_d[tail_q]    = issue_id;
            rd_d[tail_q]    = issue_rd;
            wb_d[tail_q]    = issue_writeback;
            tail_d          = tail_q + 1'b1;
        end
    end

    // State registers with synchronous reset discarding all entries
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                done_q[i]  <= 1'b0;
                id_q[i]    <= '0;
                rd_q[i]    <= '0;
                wb_q[i]    <= 1'b0;
                data_q[i]  <= '0;
                exc_q[i]   <= 1'b0;
                code_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            code_q  <= code_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_xif_id_tracker.sv
// Bench for xif_id_tracker: directed scenarios plus random traffic
// checked against an age-ordered queue model.
module tb_xif_id_tracker;
    localparam int DEPTH = 4;
    localparam int IW    = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, issue_ready, issue_accept, issue_writeback;
    logic [IW-1:0] issue_id;
    logic [4:0]    issue_rd;
    logic          commit_valid, commit_kill;
    logic [IW-1:0] commit_id;
    logic          exec_valid, exec_exc;
    logic [IW-1:0] exec_id;
    logic [DW-1:0] exec_data;
    logic [5:0]    exec_exccode;
    logic          result_valid, result_ready, result_we, result_exc;
    logic [IW-1:0] result_id;
    logic [DW-1:0] result_data;
    logic [4:0]    result_rd;
    logic [5:0]    result_exccode;
    logic [2:0]    count;

    xif_id_tracker #(.DEPTH(DEPTH), .X_ID_WIDTH(IW), .X_RFW_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_accept(issue_accept), .issue_writeback(issue_writeback),
        .issue_id(issue_id), .issue_rd(issue_rd),
        .commit_valid(commit_valid), .commit_id(commit_id),
        .commit_kill(commit_kill),
        .exec_valid(exec_valid), .exec_id(exec_id), .exec_data(exec_data),
        .exec_exc(exec_exc), .exec_exccode(exec_exccode),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_id(result_id), .result_data(result_data),
        .result_rd(result_rd), .result_we(result_we),
        .result_exc(result_exc), .result_exccode(result_exccode),
        .count(count)
    );

    always #5 clk = ~clk;

    localparam int ISS = 1;
    localparam int CMT = 2;
    localparam int KIL = 3;

    typedef struct {
        int            st;
        bit            done;
        logic [IW-1:0] id;
        logic [4:0]    rd;
        bit            wb;
        logic [DW-1:0] data;
        bit            exc;
        logic [5:0]    code;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset           = 1'b0;
        issue_valid     = 1'b0;
        issue_accept    = 1'b0;
        issue_writeback = 1'b0;
        issue_id        = '0;
        issue_rd        = '0;
        commit_valid    = 1'b0;
        commit_id       = '0;
        commit_kill     = 1'b0;
        exec_valid      = 1'b0;
        exec_id         = '0;
        exec_data       = '0;
        exec_exc        = 1'b0;
        exec_exccode    = '0;
        result_ready    = 1'b0;
    endtask

    // Compare outputs with the model, then advance the model one edge.
    task automatic cycle();
        bit   rv, pop, alc;
        int   ci, ei;
        ent_t e;
        #1;
        rv = q.size() > 0 && q[0].st == CMT && q[0].done;
        check("issue_ready", issue_ready, q.size() != DEPTH);
        check("count", count, q.size());
        check("result_valid", result_valid, rv);
        check("result_id", result_id, rv ? q[0].id : 0);
        check("result_data", result_data, rv ? q[0].data : 0);
        check("result_rd", result_rd, rv ? q[0].rd : 0);
        check("result_we", result_we, rv && q[0].wb && !q[0].exc);
        check("result_exc", result_exc, rv && q[0].exc);
        check("result_exccode", result_exccode, rv ? q[0].code : 0);
        if (reset) begin
            q.delete();
        end else begin
            ci = -1;
            ei = -1;
            foreach (q[i]) begin
                if (ci < 0 && commit_valid && q[i].st == ISS &&
                    q[i].id == commit_id) ci = i;
                if (ei < 0 && exec_valid && !q[i].done &&
                    q[i].id == exec_id) ei = i;
            end
            pop = q.size() > 0 &&
                  ((rv && result_ready) || q[0].st == KIL);
            alc = issue_valid && issue_accept && q.size() < DEPTH;
            if (ci >= 0) q[ci].st = commit_kill ? KIL : CMT;
            if (ei >= 0) begin
                q[ei].done = 1;
                q[ei].data = exec_data;
                q[ei].exc  = exec_exc;
                q[ei].code = exec_exccode;
            end
            if (pop) void'(q.pop_front());
            if (alc) begin
                e.st   = ISS;
                e.done = 0;
                e.id   = issue_id;
                e.rd   = issue_rd;
                e.wb   = issue_writeback;
                e.data = '0;
                e.exc  = 0;
                e.code = '0;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic iss(input int id, input int rd, input bit wb);
        idle();
        issue_valid     = 1'b1;
        issue_accept    = 1'b1;
        issue_writeback = wb;
        issue_id        = IW'(id);
        issue_rd        = 5'(rd);
        cycle();
    endtask

    task automatic cmt(input int id, input bit kill);
        idle();
        commit_valid = 1'b1;
        commit_id    = IW'(id);
        commit_kill  = kill;
        cycle();
    endtask

    task automatic exe(input int id, input logic [DW-1:0] d,
                       input bit x, input int code);
        idle();
        exec_valid   = 1'b1;
        exec_id      = IW'(id);
        exec_data    = d;
        exec_exc     = x;
        exec_exccode = 6'(code);
        cycle();
    endtask

    task automatic pop1();
        idle();
        result_ready = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_ready", issue_ready, 1);
        check("rst_rvalid", result_valid, 0);

        // basic flow
        iss(3, 5, 1);
        cmt(3, 0);
        exe(3, 32'h3F80_0000, 0, 0);
        check("basic_rv", result_valid, 1);
        check("basic_id", result_id, 3);
        check("basic_rd", result_rd, 5);
        check("basic_we", result_we, 1);
        check("basic_data", result_data, 32'h3F80_0000);
        pop1();
        check("basic_cnt0", count, 0);

        // out-of-order completion
        iss(1, 1, 1);
        iss(2, 2, 1);
        cmt(1, 0);
        cmt(2, 0);
        exe(2, 32'h2222, 0, 0);
        check("ooo_hold", result_valid, 0);
        exe(1, 32'h1111, 0, 0);
        check("ooo_first", result_id, 1);
        pop1();
        check("ooo_second", result_id, 2);
        pop1();

        // full / backpressure
        for (int i = 0; i < DEPTH; i++) iss(i, i, 1);
        check("full_ready", issue_ready, 0);
        check("full_cnt", count, 4);
        iss(9, 9, 1);
        check("full_cnt5", count, 4);
        cmt(0, 0);
        exe(0, 32'hA, 0, 0);
        pop1();
        check("full_reopen", issue_ready, 1);
        check("full_cnt3", count, 3);
        do_reset();

        // kill
        iss(7, 7, 1);
        iss(8, 8, 1);
        cmt(7, 1);
        cmt(8, 0);
        exe(8, 32'h8888, 0, 0);
        check("kill_rv", result_valid, 1);
        check("kill_id", result_id, 8);
        pop1();
        exe(7, 32'h7777, 0, 0);
        check("kill_cnt", count, 0);
        check("kill_rv0", result_valid, 0);

        // exception
        iss(5, 10, 1);
        cmt(5, 0);
        exe(5, 32'h5, 1, 2);
        check("exc_flag", result_exc, 1);
        check("exc_code", result_exccode, 2);
        check("exc_we", result_we, 0);
        pop1();

        // reset mid-operation
        iss(1, 1, 1);
        iss(2, 2, 1);
        iss(3, 3, 1);
        cmt(1, 0);
        exe(1, 32'h1, 0, 0);
        check("mid_rv", result_valid, 1);
        do_reset();
        check("mid_cnt", count, 0);
        check("mid_rv0", result_valid, 0);
        check("mid_ready", issue_ready, 1);
        exe(2, 32'h2, 0, 0);
        check("mid_stale", count, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset           = ($urandom_range(0, 199) == 0);
            issue_valid     = $urandom_range(0, 1);
            issue_accept    = ($urandom_range(0, 4) != 0);
            issue_writeback = $urandom_range(0, 1);
            issue_id        = IW'($urandom_range(0, 3));
            issue_rd        = 5'($urandom);
            commit_valid    = ($urandom_range(0, 9) < 4);
            commit_kill     = ($urandom_range(0, 3) == 0);
            commit_id       = IW'($urandom_range(0, 3));
            exec_valid      = $urandom_range(0, 1);
            exec_id         = IW'($urandom_range(0, 3));
            exec_data       = $urandom;
            exec_exc        = ($urandom_range(0, 7) == 0);
            exec_exccode    = 6'($urandom);
            result_ready    = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/xif_id_tracker.md
XIF_ID_TRACKER -- requirements
Module: xif_id_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight entries; power of two, at least 2.
REQ-002 SHALL have parameter X_ID_WIDTH, default 4, width of the instruction ID.
REQ-003 SHALL have parameter X_RFW_WIDTH, default 32, width of the result data.
REQ-004 SHALL have clk, input, 1, the single clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have issue_valid, input, 1; issue_ready, output, 1; issue_accept, input, 1; issue_writeback, input, 1; issue_id, input, X_ID_WIDTH; issue_rd, input, 5.
REQ-007 SHALL have commit_valid, input, 1; commit_id, input, X_ID_WIDTH; commit_kill, input, 1.
REQ-008 SHALL have exec_valid, input, 1; exec_id, input, X_ID_WIDTH; exec_data, input, X_RFW_WIDTH; exec_exc, input, 1; exec_exccode, input, 6. These carry completions from the FPU pipeline.
REQ-009 SHALL have result_valid, output, 1; result_ready, input, 1; result_id, output, X_ID_WIDTH; result_data, output, X_RFW_WIDTH; result_rd, output, 5; result_we, output, 1; result_exc, output, 1; result_exccode, output, 6.
REQ-010 SHALL have count, output, $clog2(DEPTH+1), number of occupied entries.

Function
REQ-011 SHALL be a circular buffer of DEPTH entries with head/tail pointers wrapping modulo DEPTH.
REQ-012 Each entry SHALL hold: state (FREE, ISSUED, COMMITTED, KILLED), done flag, id, rd, writeback, data, exc, exccode.
REQ-013 issue_ready SHALL equal (count != DEPTH), depending on registered state only; a same-cycle pop SHALL NOT raise it.
REQ-014 An entry SHALL be allocated at the tail only when issue_valid & issue_ready & issue_accept are all high. The new entry is ISSUED with done=0, and the tail increments.
REQ-015 A handshake with issue_accept=0 SHALL allocate nothing.
REQ-016 On commit_valid, the oldest ISSUED entry whose id matches commit_id SHALL become COMMITTED if commit_kill=0, or KILLED if commit_kill=1.
REQ-017 A commit whose id matches no ISSUED entry SHALL be ignored, including an entry allocated in the same cycle.
REQ-018 On exec_valid, the oldest non-FREE entry with done=0 and matching id SHALL latch data, exc and exccode and set done=1. A non-matching exec SHALL be ignored.
REQ-019 Commit and exec targeting the same entry in one cycle SHALL both take effect.
REQ-020 result_valid SHALL be high exactly when the head entry is COMMITTED with done=1. Results are delivered strictly in issue order.
REQ-021 result_* SHALL be driven combinationally from the head entry: result_we = writeback & ~exc. When result_valid=0, all result_* outputs SHALL be zero.
REQ-022 result_valid & result_ready SHALL free the head entry and advance head. result_valid SHALL stay asserted with stable fields until the transfer completes.
REQ-023 A KILLED head entry SHALL be freed in one cycle without a result, regardless of done; a later exec for its id is ignored per REQ-018.
REQ-024 Latency: a completion or commit that makes the head eligible in cycle N SHALL give result_valid=1 in cycle N+1. With the head already eligible and result_ready=1, one result SHALL be delivered per cycle.
REQ-025 count SHALL be updated each cycle as +1 per allocation and -1 per free; a simultaneous allocation and free SHALL leave it unchanged.
REQ-026 Allocation when full SHALL be impossible, and freeing when empty SHALL be impossible; neither may corrupt the pointers.

Reset
REQ-027 With reset=1 at a clk edge, all entries SHALL become FREE, head=tail=0 and count=0. issue_ready SHALL be 1, and result_valid and all result_* SHALL be 0.
REQ-028 Reset SHALL override any same-cycle issue, commit, exec or pop. All in-flight entries SHALL be discarded silently.

Verification
REQ-029 Basic flow: issue id=3 rd=5 wb=1; commit id=3 kill=0; exec id=3 data=0x3F800000 -> result_valid the next cycle with id=3, rd=5, we=1, data=0x3F800000; count returns to 0 after result_ready.
REQ-030 Out-of-order completion: issue ids 1,2; commit both; exec 2 then 1 -> results delivered as id 1 then id 2, never 2 first.
REQ-031 Full/backpressure: DEPTH=4, issue 4 with result_ready=0 -> issue_ready=0 and count=4. The 5th issue_valid allocates nothing. The first pop raises issue_ready in the next cycle.
REQ-032 Kill: issue 7,8; kill 7; commit 8; exec 8 -> entry 7 dropped with no result; a single result id=8 is delivered; a later exec id=7 is ignored.
REQ-033 Exception: exec with exc=1, exccode=2 on a wb=1 entry -> result_exc=1, result_exccode=2, result_we=0.
REQ-034 Reset mid-operation: 3 entries outstanding, one result_valid held, then assert reset -> next cycle count=0, result_valid=0, issue_ready=1; stale exec ids are ignored afterwards.
